// File: rtl/comparator_pkg.sv
// Shared types and defaults for the pipelined magnitude comparator.
// Optional feature macro: COMPARATOR_MINMAX_EN (adds Min_Out/Max_Out on the top).
`timescale 1ns / 1ps
package comparator_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_result_t;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_SLICE_WIDTH = 8;

  // An already resolved LT/GT wins; only an EQ-so-far result looks at this slice.
  function automatic cmp_result_t slice_resolve(cmp_result_t prev, logic slice_lt,
                                                logic slice_gt);
    cmp_result_t res;
    res = prev;
    if (prev == CMP_EQ) begin
      if (slice_lt) begin
        res = CMP_LT;
      end else if (slice_gt) begin
        res = CMP_GT;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/comparator_slice_stage.sv
// One pipeline stage of the comparator: resolves one operand slice (counted
// from the MSB end) unless an earlier stage already decided, and carries the
// operand pair to the next stage.
// Optional feature macro: COMPARATOR_MINMAX_EN (carries un-inverted operands too).
`timescale 1ns / 1ps
module comparator_slice_stage
  import comparator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned SLICE_WIDTH = DEFAULT_SLICE_WIDTH,
  parameter int unsigned SLICE_INDEX = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  prev_valid,
  input  logic [1:0]            prev_result,
  input  logic [DATA_WIDTH-1:0] prev_a,
  input  logic [DATA_WIDTH-1:0] prev_b,
`ifdef COMPARATOR_MINMAX_EN
  input  logic [DATA_WIDTH-1:0] prev_orig_a,
  input  logic [DATA_WIDTH-1:0] prev_orig_b,
  output logic [DATA_WIDTH-1:0] orig_a,
  output logic [DATA_WIDTH-1:0] orig_b,
`endif
  output logic                  valid,
  output logic [1:0]            result,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b
);

  localparam int unsigned SLICE_HI = DATA_WIDTH - 1 - SLICE_INDEX * SLICE_WIDTH;

  logic [SLICE_WIDTH-1:0] slice_a;
  logic [SLICE_WIDTH-1:0] slice_b;
  cmp_result_t            result_d;
  cmp_result_t            result_q;
  logic                   valid_q;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;

  assign slice_a = prev_a[SLICE_HI -: SLICE_WIDTH];
  assign slice_b = prev_b[SLICE_HI -: SLICE_WIDTH];

  // Next partial result: keep an earlier decision, otherwise compare this slice.
  always_comb begin
    result_d = slice_resolve(cmp_result_t'(prev_result), slice_a < slice_b, slice_a > slice_b);
  end

  // Valid bit: the only reset state, cleared asynchronously so in-flight pairs vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      valid_q <= prev_valid;
    end
  end

  // Payload registers: no reset, qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (advance) begin
      result_q <= result_d;
      a_q      <= prev_a;
      b_q      <= prev_b;
    end
  end

`ifdef COMPARATOR_MINMAX_EN
  logic [DATA_WIDTH-1:0] orig_a_q;
  logic [DATA_WIDTH-1:0] orig_b_q;

  // Original operands ride alongside for the min/max outputs.
  always_ff @(posedge clk) begin
    if (advance) begin
      orig_a_q <= prev_orig_a;
      orig_b_q <= prev_orig_b;
    end
  end

  assign orig_a = orig_a_q;
  assign orig_b = orig_b_q;
`endif

  assign valid  = valid_q;
  assign result = result_q;
  assign a      = a_q;
  assign b      = b_q;

endmodule

// File: rtl/comparator_pipelined.sv
// Pipelined magnitude comparator with valid/ready handshake. One slice of
// SLICE_WIDTH bits is resolved per stage, MSB slice first; latency is
// DATA_WIDTH/SLICE_WIDTH cycles and the whole pipe stalls on backpressure.
// Optional feature macro: COMPARATOR_MINMAX_EN (adds Min_Out and Max_Out).
`timescale 1ns / 1ps
module comparator_pipelined
  import comparator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned SLICE_WIDTH = DEFAULT_SLICE_WIDTH
) (
  input  logic                  Clock_In,
  input  logic                  Reset_N_In,
  input  logic                  In_Valid_In,
  output logic                  In_Ready_Out,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  input  logic                  Signed_In,
  output logic                  Out_Valid_Out,
  input  logic                  Out_Ready_In,
`ifdef COMPARATOR_MINMAX_EN
  output logic [DATA_WIDTH-1:0] Min_Out,
  output logic [DATA_WIDTH-1:0] Max_Out,
`endif
  output logic                  A_Less_Than_B_Out,
  output logic                  A_Equal_To_B_Out,
  output logic                  A_Greater_Than_B_Out
);

  localparam int unsigned NUM_STAGES = DATA_WIDTH / SLICE_WIDTH;

  logic                  valid_chain  [NUM_STAGES+1];
  logic [1:0]            result_chain [NUM_STAGES+1];
  logic [DATA_WIDTH-1:0] a_chain      [NUM_STAGES+1];
  logic [DATA_WIDTH-1:0] b_chain      [NUM_STAGES+1];
`ifdef COMPARATOR_MINMAX_EN
  logic [DATA_WIDTH-1:0] orig_a_chain [NUM_STAGES+1];
  logic [DATA_WIDTH-1:0] orig_b_chain [NUM_STAGES+1];
`endif

  logic        advance;
  cmp_result_t final_result;

  // The pipe moves as a whole: whenever the output slot is free or being drained.
  assign advance       = Out_Ready_In | ~Out_Valid_Out;
  assign In_Ready_Out  = advance;
  assign Out_Valid_Out = valid_chain[NUM_STAGES];

  // Flipping the MSB maps two's-complement order onto unsigned order.
  assign valid_chain[0]  = In_Valid_In;
  assign result_chain[0] = CMP_EQ;
  assign a_chain[0]      = {Data_A_In[DATA_WIDTH-1] ^ Signed_In, Data_A_In[DATA_WIDTH-2:0]};
  assign b_chain[0]      = {Data_B_In[DATA_WIDTH-1] ^ Signed_In, Data_B_In[DATA_WIDTH-2:0]};
`ifdef COMPARATOR_MINMAX_EN
  assign orig_a_chain[0] = Data_A_In;
  assign orig_b_chain[0] = Data_B_In;
`endif

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    comparator_slice_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SLICE_WIDTH (SLICE_WIDTH),
      .SLICE_INDEX (k)
    ) u_stage (
      .clk         (Clock_In),
      .rst_n       (Reset_N_In),
      .advance     (advance),
      .prev_valid  (valid_chain[k]),
      .prev_result (result_chain[k]),
      .prev_a      (a_chain[k]),
      .prev_b      (b_chain[k]),
`ifdef COMPARATOR_MINMAX_EN
      .prev_orig_a (orig_a_chain[k]),
      .prev_orig_b (orig_b_chain[k]),
      .orig_a      (orig_a_chain[k+1]),
      .orig_b      (orig_b_chain[k+1]),
`endif
      .valid       (valid_chain[k+1]),
      .result      (result_chain[k+1]),
      .a           (a_chain[k+1]),
      .b           (b_chain[k+1])
    );
  end

  // Decode the final result; everything is held low while no result is valid.
  always_comb begin
    final_result         = cmp_result_t'(result_chain[NUM_STAGES]);
    A_Less_Than_B_Out    = 1'b0;
    A_Equal_To_B_Out     = 1'b0;
    A_Greater_Than_B_Out = 1'b0;
`ifdef COMPARATOR_MINMAX_EN
    Min_Out              = '0;
    Max_Out              = '0;
`endif
    if (Out_Valid_Out) begin
      case (final_result)
        CMP_LT: begin
          A_Less_Than_B_Out = 1'b1;
`ifdef COMPARATOR_MINMAX_EN
          Min_Out = orig_a_chain[NUM_STAGES];
          Max_Out = orig_b_chain[NUM_STAGES];
`endif
        end
        CMP_GT: begin
          A_Greater_Than_B_Out = 1'b1;
`ifdef COMPARATOR_MINMAX_EN
          Min_Out = orig_b_chain[NUM_STAGES];
          Max_Out = orig_a_chain[NUM_STAGES];
`endif
        end
        default: begin
          A_Equal_To_B_Out = 1'b1;
`ifdef COMPARATOR_MINMAX_EN
          Min_Out = orig_a_chain[NUM_STAGES];
          Max_Out = orig_a_chain[NUM_STAGES];
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_pipelined.sv
// Self-checking bench for comparator_pipelined (DATA_WIDTH=32, SLICE_WIDTH=8).
// Optional feature macro: COMPARATOR_MINMAX_EN (also checks Min_Out/Max_Out).
`timescale 1ns / 1ps
module tb_comparator_pipelined;

  typedef struct {
    logic        lt;
    logic        eq;
    logic        gt;
    logic [31:0] mn;
    logic [31:0] mx;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    exp_t        e;
  } vec_t;

  logic        Clock_In;
  logic        Reset_N_In;
  logic        In_Valid_In;
  logic        In_Ready_Out;
  logic [31:0] Data_A_In;
  logic [31:0] Data_B_In;
  logic        Signed_In;
  logic        Out_Valid_Out;
  logic        Out_Ready_In;
  logic        A_Less_Than_B_Out;
  logic        A_Equal_To_B_Out;
  logic        A_Greater_Than_B_Out;
`ifdef COMPARATOR_MINMAX_EN
  logic [31:0] Min_Out;
  logic [31:0] Max_Out;
`endif

  comparator_pipelined #(
    .DATA_WIDTH  (32),
    .SLICE_WIDTH (8)
  ) dut (
    .Clock_In             (Clock_In),
    .Reset_N_In           (Reset_N_In),
    .In_Valid_In          (In_Valid_In),
    .In_Ready_Out         (In_Ready_Out),
    .Data_A_In            (Data_A_In),
    .Data_B_In            (Data_B_In),
    .Signed_In            (Signed_In),
    .Out_Valid_Out        (Out_Valid_Out),
    .Out_Ready_In         (Out_Ready_In),
`ifdef COMPARATOR_MINMAX_EN
    .Min_Out              (Min_Out),
    .Max_Out              (Max_Out),
`endif
    .A_Less_Than_B_Out    (A_Less_Than_B_Out),
    .A_Equal_To_B_Out     (A_Equal_To_B_Out),
    .A_Greater_Than_B_Out (A_Greater_Than_B_Out)
  );

  int   checks;
  int   errors;
  int   out_seen;
  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[13];
  logic rnd_done;

  initial begin
    Clock_In = 1'b0;
    forever #5 Clock_In = ~Clock_In;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    if (s) begin
      e.lt = $signed(a) < $signed(b);
      e.gt = $signed(a) > $signed(b);
    end else begin
      e.lt = a < b;
      e.gt = a > b;
    end
    e.eq = !e.lt && !e.gt;
    e.mn = e.gt ? b : a;
    e.mx = e.lt ? b : a;
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input logic lt, input logic eq, input logic gt,
                              input logic [31:0] mn, input logic [31:0] mx);
    vec_t v;
    v.a = a; v.b = b; v.s = s;
    v.e.lt = lt; v.e.eq = eq; v.e.gt = gt; v.e.mn = mn; v.e.mx = mx;
    return v;
  endfunction

  // Offer one pair; push its expectation when the handshake will complete.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input exp_t e);
    int budget;
    Data_A_In = a; Data_B_In = b; Signed_In = s; In_Valid_In = 1'b1;
    @(negedge Clock_In);
    budget = 0;
    while (!In_Ready_Out && budget < 50) begin
      @(negedge Clock_In);
      budget++;
    end
    if (!In_Ready_Out) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1 at %0t", $time);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge Clock_In); #1;
    In_Valid_In = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 60) begin
      @(posedge Clock_In); #1;
      budget++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Output monitor: compare against the scoreboard head every cycle, pop on transfer.
  always @(negedge Clock_In) begin
    if (Reset_N_In) begin
      if (Out_Valid_Out) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output actual=valid required=idle at %0t", $time);
        end else begin
          cur = exp_q[0];
          check("lt", A_Less_Than_B_Out, cur.lt);
          check("eq", A_Equal_To_B_Out, cur.eq);
          check("gt", A_Greater_Than_B_Out, cur.gt);
`ifdef COMPARATOR_MINMAX_EN
          check("min", Min_Out, cur.mn);
          check("max", Max_Out, cur.mx);
`endif
          if (Out_Ready_In) begin
            void'(exp_q.pop_front());
            out_seen++;
          end
        end
      end else begin
        check("idle_results_low",
              {A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen0;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs[0]  = mk(32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 0, 0, 32'h0000_0001, 32'hFFFF_FFFF);
    vecs[1]  = mk(32'h0000_0001, 32'hFFFF_FFFF, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'h0000_0001);
    vecs[2]  = mk(32'h8000_0000, 32'h7FFF_FFFF, 1, 1, 0, 0, 32'h8000_0000, 32'h7FFF_FFFF);
    vecs[3]  = mk(32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000);
    vecs[4]  = mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[5]  = mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[6]  = mk(32'h1234_5600, 32'h1234_5601, 0, 1, 0, 0, 32'h1234_5600, 32'h1234_5601);
    vecs[7]  = mk(32'h1234_5601, 32'h1234_5600, 1, 0, 0, 1, 32'h1234_5600, 32'h1234_5601);
    vecs[8]  = mk(32'h0000_0000, 32'h0000_0000, 1, 0, 1, 0, 32'h0000_0000, 32'h0000_0000);
    vecs[9]  = mk(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 1, 0, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    vecs[10] = mk(32'h12FF_0000, 32'h1300_0000, 0, 1, 0, 0, 32'h12FF_0000, 32'h1300_0000);
    vecs[11] = mk(32'h0001_0000, 32'h0000_FFFF, 0, 0, 0, 1, 32'h0000_FFFF, 32'h0001_0000);
    vecs[12] = mk(32'h7FFF_FFFF, 32'h8000_0000, 1, 0, 0, 1, 32'h8000_0000, 32'h7FFF_FFFF);

    checks = 0; errors = 0; out_seen = 0; rnd_done = 1'b0;
    Reset_N_In = 1'b0; In_Valid_In = 1'b0; Out_Ready_In = 1'b1;
    Data_A_In = '0; Data_B_In = '0; Signed_In = 1'b0;

    // Reset state.
    #2;
    check("reset_out_valid", Out_Valid_Out, 0);
    check("reset_in_ready", In_Ready_Out, 1);
    check("reset_results",
          {A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out}, 0);
    repeat (3) @(posedge Clock_In);
    #1 Reset_N_In = 1'b1;
    @(posedge Clock_In); #1;

    // Latency from an empty pipe: 4 edges after the pair is presented.
    Data_A_In = vecs[0].a; Data_B_In = vecs[0].b; Signed_In = vecs[0].s;
    In_Valid_In = 1'b1;
    exp_q.push_back(vecs[0].e);
    @(posedge Clock_In); #1;
    In_Valid_In = 1'b0;
    n = 1;
    while (!Out_Valid_Out && n < 10) begin
      @(posedge Clock_In); #1;
      n++;
    end
    check("latency_cycles", n, 4);
    drain();

    // Table vectors, back to back.
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e);
    drain();

    // Backpressure: six pairs, downstream stalls for 3 cycles from cycle 5.
    seen0 = out_seen;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = 32'h0100_0000 * (i + 1) + i;
          rb = 32'h0300_0000 + 32'h0000_0100 * i;
          send(ra, rb, i[0], model(ra, rb, i[0]));
        end
      end
      begin
        repeat (5) @(posedge Clock_In);
        #1 Out_Ready_In = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge Clock_In);
          check("stall_in_ready", In_Ready_Out, 0);
          check("stall_out_valid", Out_Valid_Out, 1);
          @(posedge Clock_In); #1;
        end
        Out_Ready_In = 1'b1;
      end
    join
    drain();
    check("stall_result_count", out_seen - seen0, 6);

    // Reset mid-operation with three pairs in flight, one already at the output.
    seen0 = out_seen;
    for (int i = 0; i < 3; i++) begin
      ra = 32'hA000_0000 + i;
      rb = 32'h5000_0000;
      send(ra, rb, 1'b0, model(ra, rb, 1'b0));
    end
    @(posedge Clock_In); #1;
    #1 Reset_N_In = 1'b0;
    #1;
    check("midreset_out_valid", Out_Valid_Out, 0);
    check("midreset_results",
          {A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out}, 0);
    check("midreset_in_ready", In_Ready_Out, 1);
    exp_q.delete();
    #1 Reset_N_In = 1'b1;
    repeat (8) @(posedge Clock_In);
    #1;
    check("midreset_no_late_results", out_seen - seen0, 0);

    // Random pairs with bubbles and random downstream backpressure.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge Clock_In); #1;
          end
          ra = $urandom();
          rb = ($urandom_range(0, 3) == 0) ? ra : ((ra & 32'hFFFF_FF00) | $urandom_range(0, 255));
          rs = $urandom_range(0, 1) == 1;
          send(ra, rb, rs, model(ra, rb, rs));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge Clock_In); #1;
          Out_Ready_In = ($urandom_range(0, 3) != 0);
        end
        Out_Ready_In = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
